// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - multiplexed 4-digit 7-segment scanner (mm:ss) with adjust blink.
// Optional macro SEG_SCAN_LZB_EN blanks a leading zero in the minutes tens digit.
module seg_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] min_l,
  input  logic [4:0] min_r,
  input  logic [4:0] sec_l,
  input  logic [4:0] sec_r,
  input  logic       adj_en,
  input  logic [2:0] adj_sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic [RW-1:0] ref_q, ref_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic [1:0]    idx_q, idx_d;
  logic [4:0]    snap_q [4];
  logic [4:0]    snap_d [4];
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          ref_tick;
  logic          blink_tick;
  logic [4:0]    cur;
  logic [6:0]    dec;
  logic          blank;

  always_comb begin
    ref_tick    = (ref_q == RW'(REFRESH_DIV - 1));
    ref_d       = ref_tick ? '0 : ref_q + 1'b1;
    idx_d       = ref_tick ? idx_q + 2'd1 : idx_q;

    blink_tick  = (blink_cnt_q == BW'(BLINK_DIV - 1));
    blink_cnt_d = blink_tick ? '0 : blink_cnt_q + 1'b1;
    blink_d     = blink_tick ? ~blink_q : blink_q;

    // Snapshot only at the frame boundary so a frame never mixes old and new digits.
    snap_d = snap_q;
    if (ref_tick && (idx_q == 2'd3)) begin
      snap_d[0] = min_l;
      snap_d[1] = min_r;
      snap_d[2] = sec_l;
      snap_d[3] = sec_r;
    end

    cur = snap_q[idx_q];
    dec = SEG_DASH;
    if (!cur[4]) begin
      case (cur[3:0])
        4'd0:    dec = 7'b1000000;
        4'd1:    dec = 7'b1111001;
        4'd2:    dec = 7'b0100100;
        4'd3:    dec = 7'b0110000;
        4'd4:    dec = 7'b0011001;
        4'd5:    dec = 7'b0010010;
        4'd6:    dec = 7'b0000010;
        4'd7:    dec = 7'b1111000;
        4'd8:    dec = 7'b0000000;
        4'd9:    dec = 7'b0010000;
        default: dec = SEG_DASH;
      endcase
    end

    blank = adj_en && (adj_sel == {1'b0, idx_q}) && blink_q;
`ifdef SEG_SCAN_LZB_EN
    if ((idx_q == 2'd0) && (cur == 5'd0)) blank = 1'b1;
`else
`endif

    an_d  = ~(4'b1000 >> idx_q);
    seg_d = blank ? SEG_OFF : dec;
    dp_d  = blank ? 1'b1 : (idx_q != 2'd1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ref_q       <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      idx_q       <= 2'd0;
      for (int i = 0; i < 4; i++) snap_q[i] <= 5'd0;
      an_q        <= 4'b1111;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
    end else begin
      ref_q       <= ref_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      idx_q       <= idx_d;
      for (int i = 0; i < 4; i++) snap_q[i] <= snap_d[i];
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - randomized and directed bench for seg_scan against a cycle-count model.
module tb_seg_scan;
  localparam int R = 4;
  localparam int B = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] min_l = 5'd0, min_r = 5'd0, sec_l = 5'd0, sec_r = 5'd0;
  logic       adj_en = 1'b0;
  logic [2:0] adj_sel = 3'd7;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  seg_scan #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .rst(rst), .min_l(min_l), .min_r(min_r), .sec_l(sec_l), .sec_r(sec_r),
    .adj_en(adj_en), .adj_sel(adj_sel), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

`ifdef SEG_SCAN_LZB_EN
  localparam logic [6:0] ZERO0 = 7'b1111111;
`else
  localparam logic [6:0] ZERO0 = 7'b1000000;
`endif

  logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  int checks = 0;
  int fails  = 0;
  int n = 0;
  logic [4:0] msnap [4];
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  // Model: outputs after the n-th clock since reset release show slot (n/R)%4,
  // blink phase (n/B)%2, and the digits captured at the last edge with n%(4R)==4R-1.
  task automatic step();
    int slot, phase;
    logic [4:0] v;
    logic blank;
    @(posedge clk);
    if (!rst) begin
      exp_an = 4'b1111; exp_seg = 7'b1111111; exp_dp = 1'b1;
      n = 0;
      for (int i = 0; i < 4; i++) msnap[i] = 5'd0;
    end else begin
      slot  = (n / R) % 4;
      phase = (n / B) % 2;
      v = msnap[slot];
      exp_an = 4'b1111;
      exp_an[3 - slot] = 1'b0;
      exp_seg = (v > 5'd9) ? 7'b0111111 : seg_tbl[v[3:0]];
      blank = adj_en && (int'(adj_sel) == slot) && (phase == 1);
`ifdef SEG_SCAN_LZB_EN
      if (slot == 0 && v == 5'd0) blank = 1'b1;
`endif
      if (blank) exp_seg = 7'b1111111;
      exp_dp = blank ? 1'b1 : (slot != 1);
      if (n % (4 * R) == 4 * R - 1) begin
        msnap[0] = min_l; msnap[1] = min_r; msnap[2] = sec_l; msnap[3] = sec_r;
      end
      n++;
    end
    #1;
  endtask

  task automatic do_reset(input int k);
    rst = 1'b0;
    for (int i = 0; i < k; i++) step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
      fails++; $display("FAIL reset_hold an=%b seg=%b dp=%b required 1111 1111111 1", an, seg, dp);
    end
    rst = 1'b1;
    step();
    checks++;
    if (an !== 4'b0111 || seg !== ZERO0 || dp !== 1'b1) begin
      fails++; $display("FAIL reset_release an=%b seg=%b dp=%b required 0111 %b 1", an, seg, dp, ZERO0);
    end
  endtask

  task automatic test_frames();
    do_reset(2);
    min_l = 5'd1; min_r = 5'd2; sec_l = 5'd3; sec_r = 5'd4;
    for (int c = 0; c < 48; c++) begin
      if (n == 24) sec_r = 5'd5;
      step();
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        fails++;
        $display("FAIL frames n=%0d an=%b/%b seg=%b/%b dp=%b/%b", n - 1, an, exp_an, seg, exp_seg, dp, exp_dp);
      end
      if (n - 1 == 16 || n - 1 == 20 || n - 1 == 28 || n - 1 == 44) begin
        checks++;
        if ((n - 1 == 16 && (an !== 4'b0111 || seg !== 7'b1111001)) ||
            (n - 1 == 20 && (an !== 4'b1011 || seg !== 7'b0100100 || dp !== 1'b0)) ||
            (n - 1 == 28 && (an !== 4'b1110 || seg !== 7'b0011001)) ||
            (n - 1 == 44 && (an !== 4'b1110 || seg !== 7'b0010010))) begin
          fails++; $display("FAIL frame_literal n=%0d an=%b seg=%b dp=%b", n - 1, an, seg, dp);
        end
      end
    end
  endtask

  task automatic test_blink();
    do_reset(1);
    min_l = 5'd1; min_r = 5'd2; sec_l = 5'd3; sec_r = 5'd4;
    adj_en = 1'b1; adj_sel = 3'd2;
    for (int c = 0; c < 96; c++) begin
      if (c == 64) adj_sel = 3'd5;
      step();
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        fails++;
        $display("FAIL blink n=%0d an=%b/%b seg=%b/%b dp=%b/%b", n - 1, an, exp_an, seg, exp_seg, dp, exp_dp);
      end
    end
    adj_en = 1'b0;
  endtask

  task automatic test_invalid();
    do_reset(1);
    min_l = 5'd0; min_r = 5'd12; sec_l = 5'd17; sec_r = 5'd9;
    for (int c = 0; c < 32; c++) begin
      step();
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        fails++;
        $display("FAIL invalid n=%0d an=%b/%b seg=%b/%b dp=%b/%b", n - 1, an, exp_an, seg, exp_seg, dp, exp_dp);
      end
      if (n - 1 == 16 || n - 1 == 20) begin
        checks++;
        if ((n - 1 == 16 && seg !== ZERO0) || (n - 1 == 20 && seg !== 7'b0111111)) begin
          fails++; $display("FAIL invalid_literal n=%0d seg=%b", n - 1, seg);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset(1);
    min_l = 5'd7; min_r = 5'd8; sec_l = 5'd9; sec_r = 5'd6;
    while (n < 16 + 2 * R + 1) step();
    rst = 1'b0;
    step();
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
      fails++; $display("FAIL mid_reset an=%b seg=%b dp=%b required 1111 1111111 1", an, seg, dp);
    end
    rst = 1'b1;
    step();
    checks++;
    if (an !== 4'b0111 || seg !== ZERO0) begin
      fails++; $display("FAIL mid_reset_release an=%b seg=%b required 0111 %b", an, seg, ZERO0);
    end
  endtask

  task automatic test_random();
    do_reset(1);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: min_l = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
          1: min_r = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
          2: sec_l = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
          default: sec_r = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
        endcase
      end
      if ($urandom_range(0, 29) == 0) adj_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) adj_sel = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      step();
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        fails++;
        $display("FAIL random c=%0d an=%b/%b seg=%b/%b dp=%b/%b", c, an, exp_an, seg, exp_seg, dp, exp_dp);
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) msnap[i] = 5'd0;
    test_reset();
    test_frames();
    test_blink();
    test_invalid();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles per digit slot (minimum 2).
REQ-002 Parameter BLINK_DIV, default 25000000, clk cycles per blink half-period (minimum 2).
REQ-003 clk  input  1  single system clock; all state changes on posedge clk.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on posedge clk.
REQ-005 min_l  input  5  minutes tens digit, BCD in bits [3:0].
REQ-006 min_r  input  5  minutes ones digit, BCD in bits [3:0].
REQ-007 sec_l  input  5  seconds tens digit, BCD in bits [3:0].
REQ-008 sec_r  input  5  seconds ones digit, BCD in bits [3:0].
REQ-009 adj_en  input  1  adjust mode active; enables blinking.
REQ-010 adj_sel  input  3  digit under adjustment: 0=min_l, 1=min_r, 2=sec_l, 3=sec_r, 4-7=none.
REQ-011 an  output  4  digit enables, active-low; an[3]=min_l ... an[0]=sec_r.
REQ-012 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-013 dp  output  1  decimal point, active-low.

Function
REQ-014 Refresh counter counts 0..REFRESH_DIV-1 and wraps; wrap cycle is the slot tick.
REQ-015 2-bit slot index idx advances 0->1->2->3->0 on each slot tick; idx 0 = min_l, 1 = min_r, 2 = sec_l, 3 = sec_r.
REQ-016 Snapshot registers capture all four digit inputs on the tick where idx goes 3->0; displayed values come only from the snapshot (no tearing within a frame).
REQ-017 an, seg, dp are registered; they reflect the current idx and snapshot one clk after idx changes.
REQ-018 an drives exactly one bit low: an = ~(4'b1000 >> idx).
REQ-019 Decode of snapshot[3:0]: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-020 Snapshot value 10-31 (bit 4 or [3:0]>9) displays dash 0111111.
REQ-021 dp is 0 only while idx==1 (colon position), else 1.
REQ-022 Blink counter counts 0..BLINK_DIV-1 and wraps, toggling blink_phase on wrap; free-running regardless of adj_en.
REQ-023 When adj_en=1, adj_sel==idx, and blink_phase=1: seg=1111111 and dp=1; an unchanged.
REQ-024 adj_sel 4-7 or adj_en=0: no digit blanked by blink.
REQ-025 adj_sel and adj_en act on the next registered output update; they are not snapshotted.

Reset
REQ-026 With rst=0 at posedge clk: refresh counter, blink counter, blink_phase, idx, and snapshots all 0.
REQ-027 Outputs during reset: an=1111, seg=1111111, dp=1.
REQ-028 The first clk with rst=1 produces idx-0 outputs from the zeroed snapshot: an=0111, seg=1000000.
REQ-029 Reset asserted mid-frame aborts the frame; no partial snapshot is retained.

Configuration
REQ-030 With macro SEG_SCAN_LZB_EN defined, a min_l snapshot of 0 displays blank (1111111) on slot 0.
REQ-031 Without SEG_SCAN_LZB_EN, a min_l snapshot of 0 displays 1000000; all other behaviour is identical.

Verification (REFRESH_DIV=4, BLINK_DIV=16)
REQ-032 Reset, digits 1,2,3,4 -> frame 1 shows 0,0,0,0; frame 2 shows an 0111/1011/1101/1110 with seg 1111001/0100100/0110000/0011001, each held 4 clk, dp=0 only on an=1011.
REQ-033 sec_r changes 4->5 during slot 2 -> slot 3 still shows 0011001; next frame shows 0010010.
REQ-034 adj_en=1, adj_sel=2, sec_l=3 -> on an=1101, seg alternates 0110000 and 1111111 every 16 clk; other digits unaffected; adj_sel=5 -> no blanking.
REQ-035 min_r=12 (invalid) -> slot 1 seg=0111111.
REQ-036 Reset pulsed during slot 2 -> next clk an=1111, seg=1111111; after release an=0111, seg=1000000.
REQ-037 min_l=0 -> slot 0 seg=1111111 with SEG_SCAN_LZB_EN, 1000000 without.
